// File: rtl/rv32i_exec_unit.sv
// RV32I execute stage: decodes one instruction per cycle, generates immediates,
// runs the ALU and branch comparator, and registers every result one cycle later.
module rv32i_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [4:0]  rd_idx,
    output logic        rd_write,
    output logic [1:0]  rd_src,
    output logic [31:0] result,
    output logic [31:0] link,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic        branch_taken,
    output logic        stop,
    output logic [1:0]  error
);
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND
    } alu_op_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        eq, lt, ltu;

    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign eq  = (rs1_data == rs2_data);
    assign lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign ltu = (rs1_data < rs2_data);

    alu_op_t     alu_op;
    logic [31:0] src1, src2, alu_out, res;
    logic [1:0]  src_sel;
    logic        wr, st, take, brk, illegal, jalr, alu_err;

    always_comb begin
        alu_op  = ALU_ADD;
        src1    = rs1_data;
        src2    = imm_i;
        wr      = 1'b0;
        src_sel = 2'd0;
        st      = 1'b0;
        take    = 1'b0;
        brk     = 1'b0;
        illegal = 1'b0;
        jalr    = 1'b0;
        case (opcode)
            OP_LUI:   begin src1 = '0; src2 = imm_u; wr = 1'b1; end
            OP_AUIPC: begin src1 = pc; src2 = imm_u; wr = 1'b1; end
            OP_JAL:   begin src1 = pc; src2 = imm_j; wr = 1'b1; src_sel = 2'd2; take = 1'b1; end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wr = 1'b1; src_sel = 2'd2; take = 1'b1; jalr = 1'b1;
                end else illegal = 1'b1;
            end
            OP_BRANCH: begin
                src1 = pc;
                src2 = imm_b;
                case (funct3)
                    3'b000:  take = eq;
                    3'b001:  take = ~eq;
                    3'b100:  take = lt;
                    3'b101:  take = ~lt;
                    3'b110:  take = ltu;
                    3'b111:  take = ~ltu;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin wr = 1'b1; src_sel = 2'd1; end
                else illegal = 1'b1;
            end
            OP_STORE: begin
                src2 = imm_s;
                if (funct3 == 3'b010) st = 1'b1;
                else illegal = 1'b1;
            end
            OP_IMM: begin
                wr = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: if (funct7 == 7'h00) alu_op = ALU_SLL; else illegal = 1'b1;
                    default: begin
                        if (funct7 == 7'h00)      alu_op = ALU_SRL;
                        else if (funct7 == 7'h20) alu_op = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                wr   = 1'b1;
                src2 = rs2_data;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_SYSTEM: begin
                if (instr == 32'h0010_0073) brk = 1'b1;
                else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Unsupported words become a NOP; writes to x0 are suppressed here too.
        if (illegal) begin
            wr = 1'b0; st = 1'b0; take = 1'b0; src_sel = 2'd0;
        end
        if (instr[11:7] == 5'd0) wr = 1'b0;
    end

    always_comb begin
        alu_err = 1'b0;
        case (alu_op)
            ALU_ADD:  alu_out = src1 + src2;
            ALU_SUB:  alu_out = src1 - src2;
            ALU_SLL:  alu_out = src1 << src2[4:0];
            ALU_SRL:  alu_out = src1 >> src2[4:0];
            ALU_SRA:  alu_out = $signed(src1) >>> src2[4:0];
            ALU_SLT:  alu_out = {31'b0, $signed(src1) < $signed(src2)};
            ALU_SLTU: alu_out = {31'b0, src1 < src2};
            ALU_XOR:  alu_out = src1 ^ src2;
            ALU_OR:   alu_out = src1 | src2;
            ALU_AND:  alu_out = src1 & src2;
            default: begin
                alu_out = '0;
                alu_err = 1'b1;
            end
        endcase
        if (illegal || brk) res = '0;
        else if (jalr)      res = {alu_out[31:1], 1'b0};
        else                res = alu_out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_idx       <= '0;
            rd_write     <= 1'b0;
            rd_src       <= '0;
            result       <= '0;
            link         <= '0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
            branch_taken <= 1'b0;
            stop         <= 1'b0;
            error        <= '0;
        end else begin
            rd_idx       <= instr[11:7];
            rd_write     <= wr;
            rd_src       <= src_sel;
            result       <= res;
            link         <= pc + 32'd4;
            mem_write    <= st;
            mem_wdata    <= rs2_data;
            branch_taken <= take;
            stop         <= brk;
            error        <= {illegal, alu_err};
        end
    end
endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Bench for rv32i_exec_unit: directed literal checks plus random instruction
// streams compared every cycle against an instruction-level reference model.
module tb_rv32i_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        rd_write, mem_write, branch_taken, stop;
    logic [1:0]  rd_src, error;
    logic [31:0] result, link, mem_wdata;

    int checks = 0;
    int errors = 0;

    rv32i_exec_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rd_write(rd_write), .rd_src(rd_src), .result(result), .link(link),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .branch_taken(branch_taken), .stop(stop), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd_idx;
        logic        rd_write;
        logic [1:0]  rd_src;
        logic [31:0] result;
        logic [31:0] link;
        logic        mem_write;
        logic [31:0] mem_wdata;
        logic        branch_taken;
        logic        stop;
        logic [1:0]  error;
    } exp_t;

    // Integer ALU semantics keyed by funct3, with alt selecting SUB/SRA.
    function automatic logic [31:0] arith(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: begin
                if (alt) return $signed(x) >>> y[4:0];
                return x >> y[4:0];
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   imm_i, imm_s, imm_b, imm_j;
        logic [31:0] imm_u;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit   bad;
        bit   cond;
        e     = '0;
        bad   = 0;
        cond  = 0;
        f3    = i[14:12];
        f7    = i[31:25];
        imm_i = 32'($signed(i[31:20]));
        imm_s = 32'($signed({i[31:25], i[11:7]}));
        imm_b = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        imm_j = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        imm_u = {i[31:12], 12'h000};
        e.rd_idx    = i[11:7];
        e.link      = p + 32'd4;
        e.mem_wdata = b;
        case (i[6:0])
            7'h37: begin e.result = imm_u; e.rd_write = 1; end
            7'h17: begin e.result = p + imm_u; e.rd_write = 1; end
            7'h6F: begin
                e.result = p + 32'(imm_j); e.rd_write = 1; e.rd_src = 2; e.branch_taken = 1;
            end
            7'h67: begin
                if (f3 != 0) bad = 1;
                else begin
                    e.result = (a + 32'(imm_i)) & ~32'd1;
                    e.rd_write = 1; e.rd_src = 2; e.branch_taken = 1;
                end
            end
            7'h63: begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = $signed(a) < $signed(b);
                    3'd5: cond = $signed(a) >= $signed(b);
                    3'd6: cond = a < b;
                    3'd7: cond = a >= b;
                    default: bad = 1;
                endcase
                e.result = p + 32'(imm_b);
                e.branch_taken = cond;
            end
            7'h03: begin
                if (f3 != 3'd2) bad = 1;
                else begin e.result = a + 32'(imm_i); e.rd_write = 1; e.rd_src = 1; end
            end
            7'h23: begin
                if (f3 != 3'd2) bad = 1;
                else begin e.result = a + 32'(imm_s); e.mem_write = 1; end
            end
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1;
                e.result = arith(f3, (f3 == 3'd5) && (f7 == 7'h20), a, 32'(imm_i));
                e.rd_write = 1;
            end
            7'h33: begin
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1;
                e.result = arith(f3, f7 == 7'h20, a, b);
                e.rd_write = 1;
            end
            7'h73: begin
                if (i == 32'h0010_0073) e.stop = 1;
                else bad = 1;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            e.result = 0; e.rd_write = 0; e.rd_src = 0;
            e.mem_write = 0; e.branch_taken = 0; e.error = 2'b10;
        end
        if (e.rd_idx == 0) e.rd_write = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b, input logic rst);
        @(posedge clk);
        #2;
        instr = i; pc = p; rs1_data = a; rs2_data = b; reset = rst;
    endtask

    // Expected outputs are formed at each capturing edge and compared mid-cycle.
    exp_t expv;
    bit   have_exp = 0;

    always @(posedge clk) begin
        expv     = reset ? model(instr, pc, rs1_data, rs2_data) : '0;
        have_exp = 1;
    end

    always @(negedge clk) begin
        if (have_exp) begin
            checkOutput("m_rd_idx",   32'(rd_idx),       32'(expv.rd_idx));
            checkOutput("m_rd_write", 32'(rd_write),     32'(expv.rd_write));
            checkOutput("m_rd_src",   32'(rd_src),       32'(expv.rd_src));
            checkOutput("m_result",   result,            expv.result);
            checkOutput("m_link",     link,              expv.link);
            checkOutput("m_mem_wr",   32'(mem_write),    32'(expv.mem_write));
            checkOutput("m_mem_wdata", mem_wdata,        expv.mem_wdata);
            checkOutput("m_taken",    32'(branch_taken), 32'(expv.branch_taken));
            checkOutput("m_stop",     32'(stop),         32'(expv.stop));
            checkOutput("m_error",    32'(error),        32'(expv.error));
            checkOutput("m_rs1_idx",  32'(rs1_idx),      32'(instr[19:15]));
            checkOutput("m_rs2_idx",  32'(rs2_idx),      32'(instr[24:20]));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 12))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h73;
            10: w = 32'h0010_0073;
            11: w[6:0] = 7'h13;
            default: ;
        endcase
        if (w != 32'h0010_0073 && $urandom_range(0, 2) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 70));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2: return 32'h8000_0000 + 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result",   result,            32'h0);
        checkOutput("reset_rd_write", 32'(rd_write),     32'h0);
        checkOutput("reset_error",    32'(error),        32'h0);

        applyStimulus(32'h00A0_0093, 32'h0, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("addi_result", result, 32'd10);
        checkOutput("addi_rd_idx", 32'(rd_idx), 32'd1);
        checkOutput("addi_rd_write", 32'(rd_write), 32'd1);
        checkOutput("addi_rd_src", 32'(rd_src), 32'd0);

        applyStimulus(32'h7FFF_F597, 32'h0000_000C, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("auipc_result", result, 32'h7FFF_F00C);

        applyStimulus(32'hFFFF_F537, 32'h10, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("lui_result", result, 32'hFFFF_F000);

        applyStimulus(32'hFFE0_4513, 32'h14, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("xori_result", result, 32'hFFFF_FFFE);

        applyStimulus(32'hFE20_CEE3, 32'h14, 32'd60, 32'd65, 1'b1);
        @(posedge clk); #1;
        checkOutput("blt_taken", 32'(branch_taken), 32'd1);
        checkOutput("blt_target", result, 32'h10);

        applyStimulus(32'hFE20_CEE3, 32'h14, 32'd65, 32'd64, 1'b1);
        @(posedge clk); #1;
        checkOutput("blt_not_taken", 32'(branch_taken), 32'd0);
        checkOutput("blt_rd_write", 32'(rd_write), 32'd0);

        applyStimulus(32'h0080_046F, 32'h30, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("jal_taken", 32'(branch_taken), 32'd1);
        checkOutput("jal_result", result, 32'h38);
        checkOutput("jal_link", link, 32'h34);
        checkOutput("jal_rd_src", 32'(rd_src), 32'd2);

        applyStimulus(32'hFFC6_0567, 32'h38, 32'h39, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("jalr_result", result, 32'h34);

        applyStimulus(32'hFE10_A023, 32'h40, 32'd60, 32'd60, 1'b1);
        @(posedge clk); #1;
        checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
        checkOutput("sw_result", result, 32'h1C);
        checkOutput("sw_wdata", mem_wdata, 32'd60);
        checkOutput("sw_rd_write", 32'(rd_write), 32'd0);

        applyStimulus(32'h01C0_2483, 32'h44, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("lw_result", result, 32'h1C);
        checkOutput("lw_rd_src", 32'(rd_src), 32'd1);

        applyStimulus(32'h0000_0000, 32'h48, 32'd5, 32'd6, 1'b1);
        @(posedge clk); #1;
        checkOutput("zero_error", 32'(error), 32'h2);
        checkOutput("zero_writes", 32'({rd_write, mem_write}), 32'h0);

        applyStimulus(32'h0010_0073, 32'h4C, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("ebreak_stop", 32'(stop), 32'd1);

        applyStimulus(32'h0080_046F, 32'h30, 32'd1, 32'd2, 1'b0);
        @(posedge clk); #1;
        checkOutput("midreset_taken", 32'(branch_taken), 32'd0);
        checkOutput("midreset_link", link, 32'h0);

        for (int n = 0; n < 600; n++) begin
            a = rand_data();
            applyStimulus(rand_instr(), $urandom() & ~32'd3, a,
                          ($urandom_range(0, 3) == 0) ? a : rand_data(),
                          ($urandom_range(0, 24) != 0));
        end

        repeat (2) @(posedge clk);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
